// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared FSM encoding, owner constants and default widths for the DRAM arbiter
package dram_arbiter_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_MAX_GRANT = 4;
    localparam logic OWNER_PROC = 1'b0;
    localparam logic OWNER_DMA = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ISSUE = 2'd1,
        WAIT = 2'd2,
        ACK = 2'd3
    } state_t;
endpackage

// File: rtl/dram_grant_ctr.sv
// dram_grant_ctr: saturating count of processor grants taken while DMA waits; forces a DMA grant at the limit
module dram_grant_ctr
    import dram_arbiter_pkg::*;
#(
    parameter int MAX_GRANT = DEF_MAX_GRANT
) (
    input  logic clock,
    input  logic reset,
    input  logic proc_grant,
    input  logic dma_grant,
    input  logic dma_pending,
    output logic force_dma
);
    logic [3:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (dma_grant || (proc_grant && !dma_pending)) cnt <= '0;
        else if (proc_grant && cnt != 4'(MAX_GRANT)) cnt <= cnt + 4'd1;
    end
    assign force_dma = cnt == 4'(MAX_GRANT);
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: single-port DRAM arbiter between processor and DMA ports with a bounded DMA wait.
// Every access runs IDLE -> ISSUE -> (WAIT) -> ACK; all outputs are registered.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int MAX_GRANT = DEF_MAX_GRANT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ack,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);
    state_t state, state_n;
    logic [2:0] wcnt;
    logic lat_we, force_dma, idle_ok, gnt_p, gnt_d, capture;

    dram_grant_ctr #(.MAX_GRANT(MAX_GRANT)) u_grant_ctr (
        .clock(clock),
        .reset(reset),
        .proc_grant(gnt_p),
        .dma_grant(gnt_d),
        .dma_pending(d_req),
        .force_dma(force_dma)
    );

    // the ack cycle is not a sampling cycle: a request still high there belongs to the finished access
    always_comb begin
        idle_ok = state == IDLE && !p_ack && !d_ack;
        gnt_p = idle_ok && p_req && !(d_req && force_dma);
        gnt_d = idle_ok && d_req && !gnt_p;
        capture = state == WAIT && wcnt == 3'(RD_LATENCY - 1);
        state_n = state == IDLE  ? ((gnt_p || gnt_d) ? ISSUE : IDLE) :
                  state == ISSUE ? (lat_we ? ACK : WAIT) :
                  state == WAIT  ? (capture ? ACK : WAIT) : IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
            busy <= 1'b0;
            owner <= OWNER_PROC;
            lat_we <= 1'b0;
            wcnt <= '0;
            p_ack <= 1'b0;
            d_ack <= 1'b0;
            p_rdata <= '0;
            d_rdata <= '0;
        end else begin
            ram_en <= gnt_p || gnt_d;
            ram_we <= (gnt_p && p_we) || (gnt_d && d_we);
            busy <= state_n != IDLE;
            p_ack <= state == ACK && owner == OWNER_PROC;
            d_ack <= state == ACK && owner == OWNER_DMA;
            wcnt <= state == WAIT ? wcnt + 3'd1 : 3'd0;
            if (gnt_p || gnt_d) begin
                owner <= gnt_d ? OWNER_DMA : OWNER_PROC;
                lat_we <= gnt_d ? d_we : p_we;
                ram_addr <= gnt_d ? d_addr : p_addr;
                ram_wdata <= gnt_d ? d_wdata : p_wdata;
            end
            if (capture && owner == OWNER_PROC) p_rdata <= ram_rdata;
            if (capture && owner == OWNER_DMA) d_rdata <= ram_rdata;
        end
    end
endmodule
